specialkeys_multi: RTL and testbench
====================================

Name: specialkeys_multi

Overview:
Parametrised successor of the special-key handler. Takes N raw special-key lines from the PS/2 keyboard decoder and conditions each one: 2-flop sync, cpu_ce-timed debounce, rising-edge detect. Each channel then produces an output according to a per-channel mode: level, toggle, one-shot pulse, or sticky. Sits between the keyboard decoder and the reset, ROM-disable, OSD and hold logic in the top level; BLK+SBR is two channels (sticky + one-shot) fed from the same key.

Parameters:
NKEYS, 4, number of key channels (1..16)
MODES, 32'h0000_00E4, 2 bits per channel, channel i at [2i+1:2i]: 0=level, 1=toggle, 2=oneshot, 3=sticky (default: ch0 level, ch1 toggle, ch2 oneshot, ch3 sticky)
DEB_TICKS, 4, cpu_ce ticks of stable input required to accept a change; 0 = debounce bypassed
PULSE_LEN, 8, oneshot width in cpu_ce ticks (1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_ce  in  1  CPU clock enable; time base for debounce and pulse
key_in  in  NKEYS  raw asynchronous key levels, 1 = pressed
clear  in  NKEYS  per-channel clear of toggle/sticky state (sync, level)
o_state  out  NKEYS  conditioned channel outputs
o_rise  out  NKEYS  1-clk strobe on debounced rising edge, all modes
o_busy  out  NKEYS  oneshot channel currently pulsing (0 for other modes)

Behaviour:
- Reset (sync, active-high): all sync flops, debounced levels, counters, o_state, o_rise, o_busy = 0.
- Sync: key_in passes through 2 flops; the debouncer sees only the synced value.
- Debounce per channel: counter cleared whenever synced == debounced. On cpu_ce with synced != debounced, counter increments. When it reaches DEB_TICKS the debounced level takes synced and the counter clears. DEB_TICKS=0: debounced = synced directly.
- Counter width is clog2(DEB_TICKS+1). It saturates and never wraps.
- o_rise[i]: high exactly one clk after debounced 0->1, independent of cpu_ce.
- level: o_state = debounced level.
- toggle: o_state inverts on each o_rise.
- sticky: o_state sets on o_rise. Only clear or reset returns it to 0.
- oneshot: a rise while idle sets o_state = o_busy = 1 and loads PULSE_LEN. Each subsequent cpu_ce decrements the count; the output drops on the clk where the count reaches 0, so the width is exactly PULSE_LEN cpu_ce ticks. Rises during the pulse are ignored (no retrigger).
- clear[i]: forces toggle/sticky state to 0. Ignored for level/oneshot.
- Simultaneous clear and rise on the same clk: clear wins; state stays 0, o_rise still strobes.
- cpu_ce held low: debounce and pulse freeze. Edge detect and toggle still operate on already-accepted levels.
- Latency key_in -> o_state (DEB_TICKS=0, level): 3 clk.

Optional Feature:
Macro SPECIALKEYS_CMD_EN.
- Defined: adds ports cmd_valid (in, 1), cmd_idx (in, 4), cmd_op (in, 2: 0 none, 1 set, 2 clear, 3 pulse). These let the OSD/SPI host drive channels directly.
- set/clear act on toggle/sticky state. pulse generates o_rise plus the mode action, as if the key had been pressed.
- Applied on the clk cmd_valid=1. cmd_idx >= NKEYS is ignored.
- Command and key rise on the same channel in the same clk count as one rise. Command clear beats any set.
- Undefined: ports absent; behaviour as above.

Decomposition:
- Package specialkeys_pkg holds the mode constants (MODE_LEVEL, MODE_TOGGLE, MODE_ONESHOT, MODE_STICKY) and the cmd_op codes.
- Sub-module key_debounce holds one channel's sync, debounce and rise logic. It is instantiated NKEYS times in a generate loop.
- The mode logic lives in the top module.

Test Plan:
- Level, DEB_TICKS=4, cpu_ce every 3 clk: press held 5 ticks -> o_state high after 4th stable tick, o_rise single clk; release -> low after 4 ticks.
- Bounce: key_in toggles every 2 cpu_ce for 10 ticks, then settles at 1 -> exactly one o_rise, toggle channel ends at 1.
- Oneshot, PULSE_LEN=8: press -> o_state/o_busy high exactly 8 cpu_ce ticks; second press at tick 4 -> no extension; press after end -> new 8-tick pulse.
- Sticky + clear: press -> o_state=1 persists after release; clear and a new rise on the same clk -> o_state=0, o_rise=1.
- Reset mid-pulse at tick 3 -> all outputs 0 next clk; no residual pulse after reset deasserts.
- SPECIALKEYS_CMD_EN: cmd_op=3, cmd_idx=1 on toggle channel -> o_state flips and o_rise strobes; cmd_idx=15 with NKEYS=4 -> no change.

Source files
------------

// File: rtl/specialkeys_pkg.sv
// Shared constants for the special-key channel conditioner.
// Channel modes, host command opcodes and the helper that extracts a
// channel's mode from the packed MODES parameter.
package specialkeys_pkg;

  // Per-channel output behaviour
  typedef enum logic [1:0] {
    MODE_LEVEL   = 2'd0,
    MODE_TOGGLE  = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_STICKY  = 2'd3
  } mode_e;

  // Host command opcodes (only used when the command port is built in)
  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_SET   = 2'd1,
    CMD_CLEAR = 2'd2,
    CMD_PULSE = 2'd3
  } cmd_op_e;

  localparam int unsigned CMD_IDX_W = 4;
  localparam int unsigned PULSE_W   = 8;
  localparam int unsigned MODE_W    = 2;

  // Mode of channel idx, packed two bits per channel starting at bit 0
  function automatic mode_e chan_mode(input logic [31:0] modes, input int unsigned idx);
    return mode_e'(modes[MODE_W*idx +: MODE_W]);
  endfunction

endpackage

// File: rtl/specialkeys_multi_key_debounce.sv
// One special-key input lane: 2-flop synchroniser, cpu_ce-timed debounce
// and debounced rising-edge detection. DEB_TICKS = 0 bypasses the debounce.
module key_debounce #(
  parameter int unsigned DEB_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_cpu_ce,
  input  logic i_key,
  output logic o_deb,
  output logic o_rise_c
);

  logic r_sync1;
  logic r_sync2;
  logic r_deb_prev;
  logic w_deb;

  // Bring the asynchronous key level into the clock domain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (DEB_TICKS == 0) begin : g_bypass
      assign w_deb = r_sync2;
    end else begin : g_deb
      localparam int unsigned CNT_W = $clog2(DEB_TICKS + 1);
      logic             r_deb;
      logic [CNT_W-1:0] r_cnt;

      // Accept a new level only after DEB_TICKS consecutive differing cpu_ce ticks
      always_ff @(posedge clk) begin
        if (reset) begin
          r_deb <= 1'b0;
          r_cnt <= '0;
        end else if (r_sync2 == r_deb) begin
          r_cnt <= '0;
        end else if (i_cpu_ce) begin
          if (r_cnt >= CNT_W'(DEB_TICKS - 1)) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      assign w_deb = r_deb;
    end
  endgenerate

  // Previous debounced level for edge detection (runs every clk)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb_prev <= 1'b0;
    end else begin
      r_deb_prev <= w_deb;
    end
  end

  assign o_deb    = w_deb;
  assign o_rise_c = w_deb & ~r_deb_prev;

endmodule

// File: rtl/specialkeys_multi.sv
// Multi-channel special-key handler. Each key line is synchronised,
// debounced and edge-detected, then shaped by its per-channel mode:
// level, toggle, one-shot pulse or sticky.
// Optional macro SPECIALKEYS_CMD_EN adds a host command port
// (cmd_valid/cmd_idx/cmd_op) to set, clear or pulse any channel.
module specialkeys_multi
  import specialkeys_pkg::*;
#(
  parameter int unsigned NKEYS     = 4,
  parameter logic [31:0] MODES     = 32'h0000_00E4,
  parameter int unsigned DEB_TICKS = 4,
  parameter int unsigned PULSE_LEN = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_ce,
  input  logic [NKEYS-1:0]     key_in,
  input  logic [NKEYS-1:0]     clear,
`ifdef SPECIALKEYS_CMD_EN
  input  logic                 cmd_valid,
  input  logic [CMD_IDX_W-1:0] cmd_idx,
  input  logic [1:0]           cmd_op,
`endif
  output logic [NKEYS-1:0]     o_state,
  output logic [NKEYS-1:0]     o_rise,
  output logic [NKEYS-1:0]     o_busy
);

  generate
    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_ch
      localparam mode_e MODE = chan_mode(MODES, gi);

      logic               w_deb;
      logic               w_key_rise;
      logic               w_cmd_set;
      logic               w_cmd_clr;
      logic               w_cmd_pulse;
      logic               w_rise;
      logic               w_set;
      logic               w_clr;
      logic               r_state;
      logic               r_rise;
      logic               r_busy;
      logic [PULSE_W-1:0] r_cnt;

      key_debounce #(
        .DEB_TICKS (DEB_TICKS)
      ) u_key (
        .clk      (clk),
        .reset    (reset),
        .i_cpu_ce (cpu_ce),
        .i_key    (key_in[gi]),
        .o_deb    (w_deb),
        .o_rise_c (w_key_rise)
      );

`ifdef SPECIALKEYS_CMD_EN
      logic w_cmd_hit;
      // Indices at or above NKEYS never match any channel
      assign w_cmd_hit   = cmd_valid && (cmd_idx == CMD_IDX_W'(gi));
      assign w_cmd_set   = w_cmd_hit && (cmd_op == CMD_SET);
      assign w_cmd_clr   = w_cmd_hit && (cmd_op == CMD_CLEAR);
      assign w_cmd_pulse = w_cmd_hit && (cmd_op == CMD_PULSE);
`else
      assign w_cmd_set   = 1'b0;
      assign w_cmd_clr   = 1'b0;
      assign w_cmd_pulse = 1'b0;
`endif

      // A host pulse and a key rise in the same clk merge into one rise
      assign w_rise = w_key_rise | w_cmd_pulse;
      assign w_set  = w_cmd_set;
      assign w_clr  = clear[gi] | w_cmd_clr;

      // Mode shaping: clear beats set, set beats rise
      always_ff @(posedge clk) begin
        if (reset) begin
          r_state <= 1'b0;
          r_rise  <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_rise <= w_rise;
          case (MODE)
            MODE_LEVEL: begin
              r_state <= w_deb;
            end
            MODE_TOGGLE: begin
              if (w_clr) begin
                r_state <= 1'b0;
              end else if (w_set) begin
                r_state <= 1'b1;
              end else if (w_rise) begin
                r_state <= ~r_state;
              end
            end
            MODE_STICKY: begin
              if (w_clr) begin
                r_state <= 1'b0;
              end else if (w_set || w_rise) begin
                r_state <= 1'b1;
              end
            end
            MODE_ONESHOT: begin
              // Rises while pulsing are dropped; the count only moves on cpu_ce
              if (r_busy) begin
                if (cpu_ce) begin
                  if (r_cnt == PULSE_W'(1)) begin
                    r_state <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                  end else begin
                    r_cnt <= r_cnt - PULSE_W'(1);
                  end
                end
              end else if (w_rise) begin
                r_state <= 1'b1;
                r_busy  <= 1'b1;
                r_cnt   <= PULSE_W'(PULSE_LEN);
              end
            end
          endcase
        end
      end

      assign o_state[gi] = r_state;
      assign o_rise[gi]  = r_rise;
      assign o_busy[gi]  = r_busy;
    end
  endgenerate

endmodule

// File: tb/tb_specialkeys_multi.sv
// Bench for specialkeys_multi: directed scenarios plus random traffic,
// every clk checked against a behavioural per-channel model.
module tb_specialkeys_multi;

  localparam int unsigned NK    = 4;
  localparam logic [31:0] MODES = 32'h0000_00E4;
  localparam int unsigned DEB   = 4;
  localparam int unsigned PL    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_ce;
  logic [NK-1:0] key_in;
  logic [NK-1:0] clear;
  logic [NK-1:0] o_state;
  logic [NK-1:0] o_rise;
  logic [NK-1:0] o_busy;
`ifdef SPECIALKEYS_CMD_EN
  logic          cmd_valid;
  logic [3:0]    cmd_idx;
  logic [1:0]    cmd_op;
`endif

  int vectors = 0;
  int errors  = 0;
  int ce_div  = 0;
  int ce_period = 3;

  always #5 clk = ~clk;

  specialkeys_multi #(
    .NKEYS     (NK),
    .MODES     (MODES),
    .DEB_TICKS (DEB),
    .PULSE_LEN (PL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_ce    (cpu_ce),
    .key_in    (key_in),
    .clear     (clear),
`ifdef SPECIALKEYS_CMD_EN
    .cmd_valid (cmd_valid),
    .cmd_idx   (cmd_idx),
    .cmd_op    (cmd_op),
`endif
    .o_state   (o_state),
    .o_rise    (o_rise),
    .o_busy    (o_busy)
  );

  // Behavioural reference: pipeline history, run length of disagreement,
  // and per-mode output rules, updated once per clk.
  logic [NK-1:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_prev = '0;
  logic [NK-1:0] m_state = '0, m_rise = '0, m_busy = '0;
  int m_run [NK];
  int m_rem [NK];

  always @(posedge clk) begin : model
    logic [NK-1:0] deb_old;
    int mode;
    bit up, set, clr;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = '0;
      m_state = '0; m_rise = '0; m_busy = '0;
      for (int i = 0; i < NK; i++) begin m_run[i] = 0; m_rem[i] = 0; end
    end else begin
      deb_old = m_deb;
      for (int i = 0; i < NK; i++) begin
        mode = int'((MODES >> (2 * i)) & 32'd3);
        up  = deb_old[i] && !m_prev[i];
        set = 1'b0;
        clr = clear[i];
`ifdef SPECIALKEYS_CMD_EN
        if (cmd_valid && int'(cmd_idx) == i) begin
          if (cmd_op == 2'd1) set = 1'b1;
          if (cmd_op == 2'd2) clr = 1'b1;
          if (cmd_op == 2'd3) up  = 1'b1;
        end
`endif
        m_rise[i] = up;
        case (mode)
          0: m_state[i] = deb_old[i];
          1: begin
            if (clr) m_state[i] = 1'b0;
            else if (set) m_state[i] = 1'b1;
            else if (up) m_state[i] = !m_state[i];
          end
          3: begin
            if (clr) m_state[i] = 1'b0;
            else if (set || up) m_state[i] = 1'b1;
          end
          default: begin
            if (m_busy[i]) begin
              if (cpu_ce) begin
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) begin m_state[i] = 1'b0; m_busy[i] = 1'b0; end
              end
            end else if (up) begin
              m_state[i] = 1'b1; m_busy[i] = 1'b1; m_rem[i] = PL;
            end
          end
        endcase
        if (DEB == 0) begin
          m_deb[i] = m_s2[i];
        end else if (m_s2[i] == m_deb[i]) begin
          m_run[i] = 0;
        end else if (cpu_ce) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= DEB) begin m_deb[i] = m_s2[i]; m_run[i] = 0; end
        end
      end
      m_prev = (DEB == 0) ? m_s2 : deb_old;
      m_s2 = m_s1;
      m_s1 = key_in;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clk with the chosen cpu_ce pattern, then compare to the model
  task automatic cyc();
    if (ce_period == 0) begin
      cpu_ce = ($urandom_range(2) == 0);
    end else begin
      cpu_ce = (ce_div == 0);
      ce_div = (ce_div + 1) % ce_period;
    end
    @(posedge clk);
    #1;
    chk("state", 32'(o_state), 32'(m_state));
    chk("rise",  32'(o_rise),  32'(m_rise));
    chk("busy",  32'(o_busy),  32'(m_busy));
  endtask

  initial begin : stim
    int k, n, r;
    logic [NK-1:0] snap;
    reset = 1'b1; cpu_ce = 1'b0; key_in = '0; clear = '0;
`ifdef SPECIALKEYS_CMD_EN
    cmd_valid = 1'b0; cmd_idx = '0; cmd_op = '0;
`endif
    repeat (3) cyc();
    chk("reset_state", 32'(o_state), 32'd0);
    chk("reset_busy",  32'(o_busy),  32'd0);
    reset = 1'b0;
    repeat (4) cyc();

    // Level channel: press then release
    key_in[0] = 1'b1; k = 0; r = 0;
    while (!o_state[0] && k < 80) begin cyc(); r += int'(o_rise[0]); k++; end
    chk("lvl_high", 32'(o_state[0]), 32'd1);
    repeat (15) begin cyc(); r += int'(o_rise[0]); end
    chk("lvl_rise_once", 32'(r), 32'd1);
    key_in[0] = 1'b0; k = 0;
    while (o_state[0] && k < 80) begin cyc(); k++; end
    chk("lvl_low", 32'(o_state[0]), 32'd0);

    // Bounce on the toggle channel: flips every 2 ticks, then settles high
    r = 0;
    for (int t = 0; t < 10; t++) begin
      key_in[1] = ((t / 2) % 2 == 0);
      repeat (3) begin cyc(); r += int'(o_rise[1]); end
    end
    key_in[1] = 1'b1;
    repeat (40) begin cyc(); r += int'(o_rise[1]); end
    chk("bounce_rise_once", 32'(r), 32'd1);
    chk("bounce_toggle", 32'(o_state[1]), 32'd1);
    key_in[1] = 1'b0;
    repeat (30) cyc();

    // Oneshot: two separate presses, each a PL-tick pulse
    for (int p = 0; p < 2; p++) begin
      key_in[2] = 1'b1; k = 0;
      while (!o_busy[2] && k < 80) begin cyc(); k++; end
      chk("os_start", 32'(o_busy[2]), 32'd1);
      key_in[2] = 1'b0; n = 0; k = 0;
      while (o_busy[2] && k < 100) begin cyc(); if (cpu_ce) n++; k++; end
      chk("os_width", 32'(n), 32'(PL));
      repeat (30) cyc();
    end

    // Sticky: persists after release, clear drops it, clear beats a rise
    key_in[3] = 1'b1; k = 0;
    while (!o_state[3] && k < 80) begin cyc(); k++; end
    key_in[3] = 1'b0;
    repeat (40) cyc();
    chk("sticky_hold", 32'(o_state[3]), 32'd1);
    clear[3] = 1'b1;
    cyc();
    chk("sticky_clear", 32'(o_state[3]), 32'd0);
    key_in[3] = 1'b1; r = 0;
    repeat (40) begin cyc(); r += int'(o_rise[3]); end
    chk("clr_rise_strobe", 32'(r), 32'd1);
    chk("clr_rise_state", 32'(o_state[3]), 32'd0);
    key_in[3] = 1'b0; clear[3] = 1'b0;
    repeat (30) cyc();

    // Reset in the middle of a pulse
    key_in[2] = 1'b1; k = 0;
    while (!o_busy[2] && k < 80) begin cyc(); k++; end
    n = 0; k = 0;
    while (n < 3 && k < 40) begin cyc(); if (cpu_ce) n++; k++; end
    key_in[2] = 1'b0; reset = 1'b1;
    cyc();
    chk("rst_mid_state", 32'(o_state), 32'd0);
    chk("rst_mid_rise",  32'(o_rise),  32'd0);
    chk("rst_mid_busy",  32'(o_busy),  32'd0);
    reset = 1'b0; n = 0;
    repeat (40) begin cyc(); n += int'(o_busy[2]); end
    chk("rst_no_residual", 32'(n), 32'd0);

`ifdef SPECIALKEYS_CMD_EN
    // Host pulse on the toggle channel, then an out-of-range index
    cmd_valid = 1'b1; cmd_idx = 4'd1; cmd_op = 2'd3;
    cyc();
    cmd_valid = 1'b0;
    chk("cmd_pulse_rise", 32'(o_rise[1]), 32'd1);
    chk("cmd_pulse_flip", 32'(o_state[1]), 32'd1);
    snap = o_state;
    cmd_valid = 1'b1; cmd_idx = 4'd15; cmd_op = 2'd3;
    cyc();
    cmd_valid = 1'b0;
    chk("cmd_idx_oob_state", 32'(o_state), 32'(snap));
    chk("cmd_idx_oob_rise",  32'(o_rise),  32'd0);
    cmd_valid = 1'b1; cmd_idx = 4'd3; cmd_op = 2'd1;
    cyc();
    chk("cmd_set_sticky", 32'(o_state[3]), 32'd1);
    cmd_op = 2'd2;
    cyc();
    cmd_valid = 1'b0;
    chk("cmd_clr_sticky", 32'(o_state[3]), 32'd0);
`else
    snap = '0;
`endif

    // Random traffic with irregular cpu_ce
    ce_period = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NK; i++) begin
        if ($urandom_range(9) == 0) key_in[i] = ~key_in[i];
        clear[i] = ($urandom_range(49) == 0);
      end
      reset = ($urandom_range(999) == 0);
`ifdef SPECIALKEYS_CMD_EN
      cmd_valid = ($urandom_range(19) == 0);
      cmd_idx   = 4'($urandom_range(15));
      cmd_op    = 2'($urandom_range(3));
`endif
      cyc();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
